pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-stage register with valid/ready handshake, synchronous flush and a two-entry skid buffer. It is the successor to the plain enable register for the pipelined core: it sits between stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It sustains one transfer per cycle with a fully registered `in_ready`, and supports stall (back-pressure) and squash (flush) without external glue.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `RESET_VALUE`, `{WIDTH{1'b0}}`: value loaded into both data entries on reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous squash of all held entries.
- `in_valid` input 1: upstream offers `in_data`.
- `in_ready` output 1: stage can accept; a transfer occurs when `in_valid && in_ready`.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `out_data` output WIDTH: payload from the main entry.

## Operation
- Storage: main entry (`main_q`, `main_v`) drives the outputs. Skid entry (`skid_q`, `skid_v`) absorbs one beat when downstream stalls.
- States:
  - EMPTY: `!main_v`.
  - BUSY: `main_v && !skid_v`.
  - FULL: `main_v && skid_v`.
- `in_ready = !skid_v`, driven from a flop (no combinational path from `out_ready`).
- Transitions, with no flush:
  - EMPTY + accept → BUSY, `main_q <= in_data`.
  - BUSY + accept + drain → BUSY, `main_q <= in_data`.
  - BUSY + accept + no drain → FULL, `skid_q <= in_data`.
  - BUSY + drain + no accept → EMPTY.
  - FULL + drain → BUSY, `main_q <= skid_q`. No accept is possible because `in_ready=0`.
  - All other cases hold.
- Flush has priority over every other event. Next cycle `main_v=0` and `skid_v=0`, giving EMPTY. A beat offered or drained in the flush cycle is discarded upstream and consumed downstream respectively. Data registers are not cleared by flush.
- Data entries load only on an accept or a skid→main move. Otherwise they hold, including while invalid.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by flush.

## Timing
- Reset (async assert, `rst_n=0`):
  - `out_valid=0`, `in_ready=1`, `out_data=RESET_VALUE`, skid entry `=RESET_VALUE`.
  - Effective immediately, without a clock.
- Deassertion is taken at the next rising edge. Reset mid-transfer drops every held beat.
- Latency: a beat accepted at edge N is presented on `out_valid`/`out_data` after edge N; minimum residence is 1 cycle.
- Throughput: 1 beat/cycle while `out_ready=1`.
- Stall: the first stalled cycle fills the skid entry. `in_ready` falls after that edge and rises one edge after the first drain.
- `flush` together with `rst_n=0`: reset wins.

## Configuration
- `PIPE_STAGE_SKID_EN` defined (default build): two-entry skid behaviour as above, with registered `in_ready`.
- Not defined: the skid entry is compiled out and the block has only EMPTY/BUSY.
  - `in_ready = !main_v || out_ready`, which is combinational.
  - Full throughput is kept, but a combinational ready path runs through the stage.
  - Reset and flush behaviour are unchanged.

## Structure
- Shared package `pipe_pkg` holds:
  - the `pipe_state_e` enum (EMPTY, BUSY, FULL);
  - the constant `PIPE_STATE_W = 2`.
- One sub-module, `pipe_data_reg`: a WIDTH-bit enable register with async active-low reset to `RESET_VALUE`. It is instantiated for the main entry and, under `PIPE_STAGE_SKID_EN`, for the skid entry.
- Valid bits and next-state logic live in `pipe_stage_reg`.

## Test plan
- Reset: hold `rst_n=0` with `in_valid=1`, `in_data=32'hDEADBEEF` → `out_valid=0`, `in_ready=1`, `out_data=0`. Release, accept the beat → `out_valid=1`, `out_data=32'hDEADBEEF` next cycle.
- Streaming: `out_ready=1`, push 0x1..0x10 on consecutive cycles → outputs 0x1..0x10 on consecutive cycles, 1 cycle latency, `in_ready` never falls.
- Stall and skid: push 0xA, 0xB with `out_ready=0` → `in_ready=0` after the 0xB edge. Raise `out_ready` → 0xA then 0xB emitted in order, and `in_ready=1` one edge after the 0xA drain.
- Flush in FULL: with 0xA/0xB held, assert `flush` for one cycle with `in_valid=1`, `in_data=0xC` → next cycle `out_valid=0`, `in_ready=1`, and 0xC is never emitted.
- Async reset mid-stall: FULL state, drop `rst_n` between edges → `out_valid=0` and `out_data=RESET_VALUE` immediately, before the next edge.
- Macro off: rebuild without `PIPE_STAGE_SKID_EN`, `main_v=1`, toggle `out_ready` → `in_ready` follows `out_ready` in the same cycle. Repeat the streaming test with identical output.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage register: occupancy state encoding.
package pipe_pkg;

  localparam int unsigned PIPE_STATE_W = 2;

  typedef enum logic [PIPE_STATE_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit enable register with asynchronous active-low reset to RESET_VALUE.
module pipe_data_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush and skid buffer.
// PIPE_STAGE_SKID_EN selects the registered-ready two-entry variant.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  pipe_state_e      state_q;
  pipe_state_e      state_d;
  logic             out_valid_q;
  logic             accept;
  logic             drain;
  logic             load_main;
  logic [WIDTH-1:0] main_d;

  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign out_valid = out_valid_q;

`ifdef PIPE_STAGE_SKID_EN
  logic             ready_q;
  logic             load_skid;
  logic             main_from_skid;
  logic [WIDTH-1:0] skid_q;

  assign in_ready = ready_q;
  assign main_d   = main_from_skid ? skid_q : in_data;
`else
  // Without a skid entry, space frees up in the same cycle the beat drains.
  assign in_ready = !out_valid_q || out_ready;
  assign main_d   = in_data;
`endif

  // Occupancy state register; valid and ready are re-registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      ready_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
      ready_q     <= (state_d != FULL);
`endif
    end
  end

  // Next-state and entry-load decode; flush overrides every other event.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = BUSY;
            load_main = 1'b1;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
            state_d   = FULL;
            load_skid = 1'b1;
`endif
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (drain) begin
            state_d        = BUSY;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  pipe_data_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_main),
    .d     (main_d),
    .q     (out_data)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_data_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_skid),
    .d     (in_data),
    .q     (skid_q)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps plus random traffic against a queue model.
module tb_pipe_stage_reg;

  localparam int unsigned W = 32;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;

  logic [W-1:0] q[$];
  bit           last_accept;
  int           n_assert = 0;
  int           n_fail = 0;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Capacity 2 gives a registered ready; capacity 1 frees space as the head drains.
  function automatic logic exp_ready();
    if (SKID) return (q.size() < 2);
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("out_valid", W'(out_valid), W'(q.size() != 0));
    chk("in_ready", W'(in_ready), W'(exp_ready()));
    if (q.size() != 0) chk("out_data", out_data, q[0]);
  endtask

  task automatic model_edge();
    bit acc;
    bit dr;
    if (!rst_n) begin
      q.delete();
      last_accept = 1'b0;
      return;
    end
    acc = in_valid && exp_ready();
    dr  = (q.size() != 0) && out_ready;
    last_accept = acc;
    if (flush) begin
      q.delete();
    end else begin
      if (dr) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic fill_ab();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    cycle();
    in_data = 32'hB;
    cycle();
    in_valid = 1'b0;
    cycle();
  endtask

  initial begin
    // Reset held with a beat on offer
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_data", out_data, W'(0));
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("rst_release_data", out_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    cycle();
    cycle();

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      cycle();
      chk("stream_accept", W'(last_accept), W'(1));
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Stall then release
    fill_ab();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Flush while holding beats, with a new beat offered
    fill_ab();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hC;
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Asynchronous reset between edges while stalled
    fill_ab();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", W'(out_valid), W'(0));
    chk("async_out_data", out_data, W'(0));
    chk("async_in_ready", W'(in_ready), W'(1));
    q.delete();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = $urandom;
      cycle();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
